hpdsm_interp_feeder: RTL
========================

HPDSM_INTERP_FEEDER -- requirements
Module: hpdsm_interp_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width in bits, two's complement.
REQ-002 SHALL have parameter RATIO_LOG2, default 4: interpolation ratio N = 2^RATIO_LOG2, legal range 1..8.
REQ-003 SHALL have port clk, input, 1: the single clock for the block.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port s_data, input, WIDTH: low-rate input sample.
REQ-006 SHALL have port s_valid, input, 1: s_data is valid.
REQ-007 SHALL have port s_ready, output, 1: block accepts s_data this cycle.
REQ-008 SHALL have port xo, output, WIDTH: interpolated sample at clk rate, which drives the downstream high-pass DSM filter input.
REQ-009 SHALL have port underrun, output, 1: one-cycle pulse when a segment ends and no next sample is buffered.

Function
REQ-010 SHALL perform a transfer when s_valid and s_ready are both high on a clk edge; the transfer loads a one-entry buffer NXT.
REQ-011 SHALL drive s_ready = !NXT_valid, registered, with no combinational path from s_valid.
REQ-012 SHALL implement states IDLE, PRIME, RUN and HOLD.
REQ-013 In IDLE, xo SHALL be 0; if NXT_valid, SHALL consume NXT into B and go to PRIME.
REQ-014 In PRIME, xo SHALL equal B; if NXT_valid, SHALL start a segment from A=B to B=NXT and go to RUN.
REQ-015 Segment start SHALL:
  - set ACC = A sign-extended << RATIO_LOG2;
  - set DELTA = NXT - A, computed at WIDTH+1 bits;
  - set phase = 0;
  - consume NXT.
REQ-016 In RUN, each cycle SHALL set ACC += DELTA and phase += 1; ACC is WIDTH+RATIO_LOG2+1 bits signed.
REQ-017 xo SHALL be registered as ACC[WIDTH+RATIO_LOG2-1:RATIO_LOG2], floor rounding with no saturation; range is guaranteed because ACC stays between A and B.
REQ-018 The first xo of a segment SHALL equal A exactly, one cycle after segment start; each segment SHALL present exactly N outputs.
REQ-019 At phase = N-1 with NXT_valid, the next cycle SHALL start the next segment from the current B, giving a seamless, gap-free stream.
REQ-020 At phase = N-1 without NXT_valid, SHALL pulse underrun for one cycle, go to HOLD, and hold xo = B.
REQ-021 In HOLD, on NXT_valid SHALL start a segment from B to NXT and go to RUN.
REQ-022 Handling of simultaneous events SHALL be as follows:
  - a transfer in the same cycle NXT is consumed is impossible by REQ-011;
  - a new transfer SHALL be accepted in the cycle after consumption.
REQ-023 Sustained throughput SHALL be one input sample per N cycles with no underrun when s_valid is held high.

Reset
REQ-024 While rst is high, SHALL hold: state = IDLE, NXT_valid = 0, ACC/A/B/DELTA/phase = 0, xo = 0, underrun = 0, s_ready = 0.
REQ-025 SHALL drive s_ready = 1 on the first clk edge after rst deasserts.
REQ-026 Reset asserted mid-segment SHALL discard all buffered samples immediately and asynchronously.

Structure
REQ-027 State encodings and the N derivation (localparams) SHALL reside in shared package hpdsm_pkg.
REQ-028 Widening of A and DELTA SHALL reuse the existing sign_extend sub-module; no other sub-module.
REQ-029 The implementation SHALL be a single always block per register group, with no latches and no multipliers.

Verification (WIDTH=16, RATIO_LOG2=2, N=4)
REQ-030 Ramp test: send 0, then 400, then 800 back-to-back -> xo = 0,0…(PRIME), then 0,100,200,300,400,500,600,700, with underrun after 700.
REQ-031 Negative test: send 100, then -100 -> segment xo = 100,50,0,-50; then HOLD at -100 with a single underrun pulse.
REQ-032 Extremes test: send 32767, then -32768 -> xo = 32767,16383,-1,-16385, with no wrap or overflow.
REQ-033 Backpressure test: hold s_valid high continuously -> s_ready low while NXT is full, exactly one transfer per 4 cycles in RUN, and underrun never asserted.
REQ-034 Reset test: assert rst asynchronously mid-RUN (not on a clk edge) -> xo = 0, s_ready = 0, and state IDLE immediately; after release, a new 2-sample stream interpolates correctly.

Source files
------------

// File: rtl/hpdsm_pkg.sv
// Shared definitions for the high-pass DSM interpolating feeder.
package hpdsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Interpolation ratio N derived from its log2.
    function automatic int unsigned ratio_n(input int unsigned log2);
        return 32'd1 << log2;
    endfunction

endpackage

// File: rtl/sign_extend.sv
// Two's-complement widening from IN_W to OUT_W bits (OUT_W > IN_W).
module sign_extend #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 17
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    assign dout = {{(OUT_W - IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/hpdsm_interp_feeder.sv
// Linear interpolator: turns a low-rate sample stream into one sample per clk,
// N outputs per input, feeding the high-pass DSM filter.
module hpdsm_interp_feeder
    import hpdsm_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned RATIO_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] xo,
    output logic             underrun
);

    localparam int unsigned ACC_W = WIDTH + RATIO_LOG2 + 1;
    localparam int unsigned DW    = WIDTH + 1;
    localparam int unsigned N     = ratio_n(RATIO_LOG2);
    localparam logic [RATIO_LOG2-1:0] PH_LAST = RATIO_LOG2'(N - 1);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      nxt_q, nxt_d;
    logic                  nxt_valid_q, nxt_valid_d;
    logic                  s_ready_q;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [DW-1:0]         delta_q, delta_d;
    logic [RATIO_LOG2-1:0] phase_q, phase_d;
    logic [WIDTH-1:0]      xo_q, xo_d;
    logic                  und_pend_q, und_pend_d;
    logic                  underrun_q;

    logic                  xfer, consume, seg_start;
    logic [DW-1:0]         b_dw, nxt_dw, delta_new;
    logic [ACC_W-1:0]      b_acc, delta_acc, acc_start;

    sign_extend #(.IN_W(WIDTH), .OUT_W(DW))    u_sx_a_dw   (.din(b_q),     .dout(b_dw));
    sign_extend #(.IN_W(WIDTH), .OUT_W(DW))    u_sx_nxt_dw (.din(nxt_q),   .dout(nxt_dw));
    sign_extend #(.IN_W(WIDTH), .OUT_W(ACC_W)) u_sx_a_acc  (.din(b_q),     .dout(b_acc));
    sign_extend #(.IN_W(DW),    .OUT_W(ACC_W)) u_sx_delta  (.din(delta_q), .dout(delta_acc));

    // At segment start the current B becomes the new A.
    assign delta_new = nxt_dw - b_dw;
    assign acc_start = b_acc << RATIO_LOG2;

    assign xfer = s_valid && s_ready_q;

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        acc_d      = acc_q;
        delta_d    = delta_q;
        phase_d    = phase_q;
        xo_d       = xo_q;
        und_pend_d = 1'b0;
        consume    = 1'b0;
        seg_start  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                xo_d = '0;
                if (nxt_valid_q) begin
                    b_d     = nxt_q;
                    consume = 1'b1;
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                xo_d      = b_q;
                seg_start = nxt_valid_q;
            end
            ST_RUN: begin
                xo_d    = acc_q[WIDTH+RATIO_LOG2-1:RATIO_LOG2];
                acc_d   = acc_q + delta_acc;
                phase_d = phase_q + 1'b1;
                if (phase_q == PH_LAST) begin
                    if (nxt_valid_q) begin
                        seg_start = 1'b1;
                    end else begin
                        state_d    = ST_HOLD;
                        und_pend_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                xo_d      = b_q;
                seg_start = nxt_valid_q;
            end
            default: state_d = ST_IDLE;
        endcase

        if (seg_start) begin
            b_d     = nxt_q;
            acc_d   = acc_start;
            delta_d = delta_new;
            phase_d = '0;
            consume = 1'b1;
            state_d = ST_RUN;
        end

        nxt_valid_d = (nxt_valid_q && !consume) || xfer;
        nxt_d       = xfer ? s_data : nxt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nxt_q       <= '0;
            nxt_valid_q <= 1'b0;
            s_ready_q   <= 1'b0;
        end else begin
            nxt_q       <= nxt_d;
            nxt_valid_q <= nxt_valid_d;
            s_ready_q   <= !nxt_valid_d;
        end
    end

    // Underrun is delayed one cycle so it coincides with xo settling on B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            b_q        <= '0;
            acc_q      <= '0;
            delta_q    <= '0;
            phase_q    <= '0;
            xo_q       <= '0;
            und_pend_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            delta_q    <= delta_d;
            phase_q    <= phase_d;
            xo_q       <= xo_d;
            und_pend_q <= und_pend_d;
            underrun_q <= und_pend_q;
        end
    end

    assign s_ready  = s_ready_q;
    assign xo       = xo_q;
    assign underrun = underrun_q;

endmodule
